// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between the fetch and load/store ports.
// One transaction outstanding; a response timeout turns a hung memory into an error response.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MAX_STARVE = 4,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req_valid,
  output logic                if_req_ready,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_rsp_valid,
  output logic [DATA_W-1:0]   if_rsp_data,
  output logic                if_rsp_err,
  input  logic                dm_req_valid,
  output logic                dm_req_ready,
  input  logic                dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W/8-1:0] dm_wmask,
  output logic                dm_rsp_valid,
  output logic [DATA_W-1:0]   dm_rsp_data,
  output logic                dm_rsp_err,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_rvalid
);

  localparam int unsigned SW       = $clog2(MAX_STARVE + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_STARVE);
  localparam logic [7:0]    TMO_LAST   = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StBusyI, StBusyD} state_e;

  state_e            state_q, state_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic [7:0]        tmo_q, tmo_d;
  logic              store_q, store_d;
  logic              grant_if, grant_dm;

  logic              if_rsp_valid_q, if_rsp_valid_d;
  logic              if_rsp_err_q, if_rsp_err_d;
  logic [DATA_W-1:0] if_rsp_data_q, if_rsp_data_d;
  logic              dm_rsp_valid_q, dm_rsp_valid_d;
  logic              dm_rsp_err_q, dm_rsp_err_d;
  logic [DATA_W-1:0] dm_rsp_data_q, dm_rsp_data_d;
  logic              rsp_err;
  logic [DATA_W-1:0] rsp_data;

  always_comb begin
    state_d        = state_q;
    starve_d       = starve_q;
    tmo_d          = tmo_q;
    store_d        = store_q;
    grant_if       = 1'b0;
    grant_dm       = 1'b0;
    if_rsp_valid_d = 1'b0;
    if_rsp_err_d   = 1'b0;
    if_rsp_data_d  = if_rsp_data_q;
    dm_rsp_valid_d = 1'b0;
    dm_rsp_err_d   = 1'b0;
    dm_rsp_data_d  = dm_rsp_data_q;
    rsp_err        = 1'b0;
    rsp_data       = '0;
    mem_en         = 1'b0;
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;
    mem_wmask      = '0;

    case (state_q)
      StIdle: begin
        // Reset gating keeps readies and mem_* at zero while reset is held.
        if (!reset) begin
          if (if_req_valid && (!dm_req_valid || starve_q == STARVE_MAX)) begin
            grant_if = 1'b1;
          end else if (dm_req_valid) begin
            grant_dm = 1'b1;
          end
        end
        if (grant_if) begin
          mem_en   = 1'b1;
          mem_addr = if_addr;
          state_d  = StBusyI;
          tmo_d    = '0;
          starve_d = '0;
        end else if (grant_dm) begin
          mem_en    = 1'b1;
          mem_we    = dm_we;
          mem_addr  = dm_addr;
          mem_wdata = dm_wdata;
          mem_wmask = dm_we ? dm_wmask : '0;
          store_d   = dm_we;
          state_d   = StBusyD;
          tmo_d     = '0;
          if (if_req_valid) begin
            starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + 1'b1;
          end else begin
            starve_d = '0;
          end
        end
      end
      StBusyI, StBusyD: begin
        // A completion on the final timeout cycle still counts as a normal response.
        if (mem_rvalid || tmo_q == TMO_LAST) begin
          state_d = StIdle;
          rsp_err = !mem_rvalid;
          if (mem_rvalid && !(state_q == StBusyD && store_q)) begin
            rsp_data = mem_rdata;
          end
          if (state_q == StBusyD) begin
            dm_rsp_valid_d = 1'b1;
            dm_rsp_err_d   = rsp_err;
            dm_rsp_data_d  = rsp_data;
          end else begin
            if_rsp_valid_d = 1'b1;
            if_rsp_err_d   = rsp_err;
            if_rsp_data_d  = rsp_data;
          end
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= StIdle;
      starve_q       <= '0;
      tmo_q          <= '0;
      store_q        <= 1'b0;
      if_rsp_valid_q <= 1'b0;
      if_rsp_err_q   <= 1'b0;
      if_rsp_data_q  <= '0;
      dm_rsp_valid_q <= 1'b0;
      dm_rsp_err_q   <= 1'b0;
      dm_rsp_data_q  <= '0;
    end else begin
      state_q        <= state_d;
      starve_q       <= starve_d;
      tmo_q          <= tmo_d;
      store_q        <= store_d;
      if_rsp_valid_q <= if_rsp_valid_d;
      if_rsp_err_q   <= if_rsp_err_d;
      if_rsp_data_q  <= if_rsp_data_d;
      dm_rsp_valid_q <= dm_rsp_valid_d;
      dm_rsp_err_q   <= dm_rsp_err_d;
      dm_rsp_data_q  <= dm_rsp_data_d;
    end
  end

  assign if_req_ready = grant_if;
  assign dm_req_ready = grant_dm;
  assign if_rsp_valid = if_rsp_valid_q;
  assign if_rsp_err   = if_rsp_err_q;
  assign if_rsp_data  = if_rsp_data_q;
  assign dm_rsp_valid = dm_rsp_valid_q;
  assign dm_rsp_err   = dm_rsp_err_q;
  assign dm_rsp_data  = dm_rsp_data_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: expected responses are queued at grant time and
// compared when the response pulse appears.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req_valid = 1'b0;
  logic        if_req_ready;
  logic [31:0] if_addr = '0;
  logic        if_rsp_valid;
  logic [31:0] if_rsp_data;
  logic        if_rsp_err;
  logic        dm_req_valid = 1'b0;
  logic        dm_req_ready;
  logic        dm_we = 1'b0;
  logic [31:0] dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic [3:0]  dm_wmask = '0;
  logic        dm_rsp_valid;
  logic [31:0] dm_rsp_data;
  logic        dm_rsp_err;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_rdata = '0;
  logic        mem_rvalid = 1'b0;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MAX_STARVE(4), .TIMEOUT(16)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data), .if_rsp_err(if_rsp_err),
    .dm_req_valid(dm_req_valid), .dm_req_ready(dm_req_ready), .dm_we(dm_we),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_wmask(dm_wmask),
    .dm_rsp_valid(dm_rsp_valid), .dm_rsp_data(dm_rsp_data), .dm_rsp_err(dm_rsp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_dm;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic is_dm, input logic [31:0] data, input logic err);
    exp_t e;
    e.is_dm = is_dm;
    e.data  = data;
    e.err   = err;
    sb.push_back(e);
  endtask

  // Called #1 after a negedge: exactly the queued response must be pulsing now.
  task automatic check_rsp(input string tag);
    exp_t e;
    chk({tag, "_sb"}, 64'(sb.size() > 0), 64'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.is_dm) begin
        chk({tag, "_dm_valid"}, 64'(dm_rsp_valid), 64'd1);
        chk({tag, "_if_valid"}, 64'(if_rsp_valid), 64'd0);
        chk({tag, "_dm_data"}, 64'(dm_rsp_data), 64'(e.data));
        chk({tag, "_dm_err"}, 64'(dm_rsp_err), 64'(e.err));
      end else begin
        chk({tag, "_if_valid"}, 64'(if_rsp_valid), 64'd1);
        chk({tag, "_dm_valid"}, 64'(dm_rsp_valid), 64'd0);
        chk({tag, "_if_data"}, 64'(if_rsp_data), 64'(e.data));
        chk({tag, "_if_err"}, 64'(if_rsp_err), 64'(e.err));
      end
    end
  endtask

  task automatic expect_none(input string tag);
    chk({tag, "_if_valid"}, 64'(if_rsp_valid), 64'd0);
    chk({tag, "_dm_valid"}, 64'(dm_rsp_valid), 64'd0);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset: a valid request must not be accepted and all outputs stay low.
    step();
    if_req_valid = 1'b1;
    if_addr      = 32'h100;
    #1;
    chk("rst_if_ready", 64'(if_req_ready), 64'd0);
    chk("rst_mem_en", 64'(mem_en), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    expect_none("rst");
    chk("rst_if_data", 64'(if_rsp_data), 64'd0);
    if_req_valid = 1'b0;
    step();
    reset = 1'b0;

    // Fetch only, completion one cycle after grant.
    step();
    if_req_valid = 1'b1;
    if_addr      = 32'h100;
    #1;
    chk("f_if_ready", 64'(if_req_ready), 64'd1);
    chk("f_dm_ready", 64'(dm_req_ready), 64'd0);
    chk("f_mem_en", 64'(mem_en), 64'd1);
    chk("f_mem_addr", 64'(mem_addr), 64'h100);
    chk("f_mem_we", 64'(mem_we), 64'd0);
    push(1'b0, 32'h0050_0093, 1'b0);
    step();
    if_req_valid = 1'b0;
    mem_rvalid   = 1'b1;
    mem_rdata    = 32'h0050_0093;
    #1;
    chk("f_busy_mem_en", 64'(mem_en), 64'd0);
    expect_none("f_n1");
    step();
    mem_rvalid = 1'b0;
    #1;
    check_rsp("fetch");
    step();
    #1;
    expect_none("f_pulse");
    chk("f_data_hold", 64'(if_rsp_data), 64'h0050_0093);

    // Simultaneous requests: load wins, fetch follows once the load completes.
    if_req_valid = 1'b1;
    if_addr      = 32'h104;
    dm_req_valid = 1'b1;
    dm_we        = 1'b0;
    dm_addr      = 32'h2000;
    dm_wdata     = 32'hFFFF_FFFF;
    dm_wmask     = 4'hF;
    #1;
    chk("s_dm_ready", 64'(dm_req_ready), 64'd1);
    chk("s_if_ready", 64'(if_req_ready), 64'd0);
    chk("s_mem_addr", 64'(mem_addr), 64'h2000);
    chk("s_mem_we", 64'(mem_we), 64'd0);
    chk("s_mem_wmask", 64'(mem_wmask), 64'd0);
    push(1'b1, 32'h1111_2222, 1'b0);
    step();
    dm_req_valid = 1'b0;
    mem_rvalid   = 1'b1;
    mem_rdata    = 32'h1111_2222;
    #1;
    chk("s_busy_if_ready", 64'(if_req_ready), 64'd0);
    step();
    mem_rvalid = 1'b0;
    #1;
    check_rsp("sim_dm");
    chk("s2_if_ready", 64'(if_req_ready), 64'd1);
    chk("s2_mem_addr", 64'(mem_addr), 64'h104);
    push(1'b0, 32'h2222_3333, 1'b0);
    step();
    if_req_valid = 1'b0;
    mem_rvalid   = 1'b1;
    mem_rdata    = 32'h2222_3333;
    step();
    mem_rvalid = 1'b0;
    #1;
    check_rsp("sim_if");

    // Starvation guard: four load grants with fetch waiting, then fetch is forced through.
    step();
    if_req_valid = 1'b1;
    if_addr      = 32'h200;
    dm_req_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      dm_addr = 32'h3000 + 32'(k * 4);
      #1;
      chk($sformatf("st%0d_dm_ready", k), 64'(dm_req_ready), 64'd1);
      chk($sformatf("st%0d_if_ready", k), 64'(if_req_ready), 64'd0);
      push(1'b1, 32'(k + 16'h0A00), 1'b0);
      step();
      mem_rvalid = 1'b1;
      mem_rdata  = 32'(k + 16'h0A00);
      step();
      mem_rvalid = 1'b0;
      #1;
      check_rsp($sformatf("st%0d", k));
    end
    chk("st_if_ready", 64'(if_req_ready), 64'd1);
    chk("st_dm_ready", 64'(dm_req_ready), 64'd0);
    chk("st_mem_addr", 64'(mem_addr), 64'h200);
    push(1'b0, 32'h0000_AAAA, 1'b0);
    step();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h0000_AAAA;
    step();
    mem_rvalid = 1'b0;
    #1;
    check_rsp("st_if");
    // Counter was cleared by the fetch grant, so the load wins again.
    chk("st_after_dm_ready", 64'(dm_req_ready), 64'd1);
    chk("st_after_if_ready", 64'(if_req_ready), 64'd0);
    push(1'b1, 32'h0000_BBBB, 1'b0);
    step();
    if_req_valid = 1'b0;
    dm_req_valid = 1'b0;
    mem_rvalid   = 1'b1;
    mem_rdata    = 32'h0000_BBBB;
    step();
    mem_rvalid = 1'b0;
    #1;
    check_rsp("st_dm");

    // Store: fields pass straight through; ack data is zero regardless of mem_rdata.
    step();
    dm_req_valid = 1'b1;
    dm_we        = 1'b1;
    dm_addr      = 32'h40;
    dm_wdata     = 32'hDEAD_BEEF;
    dm_wmask     = 4'b0011;
    #1;
    chk("w_mem_en", 64'(mem_en), 64'd1);
    chk("w_mem_we", 64'(mem_we), 64'd1);
    chk("w_mem_addr", 64'(mem_addr), 64'h40);
    chk("w_mem_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
    chk("w_mem_wmask", 64'(mem_wmask), 64'h3);
    push(1'b1, 32'h0, 1'b0);
    step();
    dm_req_valid = 1'b0;
    dm_we        = 1'b0;
    mem_rvalid   = 1'b1;
    mem_rdata    = 32'h1234_5678;
    step();
    mem_rvalid = 1'b0;
    #1;
    check_rsp("store");

    // Timeout: error response exactly 17 cycles after grant, late completion ignored.
    step();
    dm_req_valid = 1'b1;
    dm_addr      = 32'h80;
    #1;
    chk("t_dm_ready", 64'(dm_req_ready), 64'd1);
    push(1'b1, 32'h0, 1'b1);
    step();
    dm_req_valid = 1'b0;
    #1;
    expect_none("t_n1");
    for (int c = 2; c <= 16; c++) begin
      step();
      #1;
      expect_none($sformatf("t_n%0d", c));
    end
    step();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h7777_7777;
    #1;
    check_rsp("timeout");
    step();
    mem_rvalid = 1'b0;
    #1;
    expect_none("t_late");
    chk("t_late_data", 64'(dm_rsp_data), 64'd0);

    // Completion on the last timeout cycle wins over the error.
    step();
    dm_req_valid = 1'b1;
    dm_addr      = 32'h84;
    #1;
    chk("tw_dm_ready", 64'(dm_req_ready), 64'd1);
    push(1'b1, 32'h0000_5555, 1'b0);
    step();
    dm_req_valid = 1'b0;
    repeat (15) step();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h0000_5555;
    step();
    mem_rvalid = 1'b0;
    #1;
    check_rsp("tmo_edge");

    // Reset one cycle after grant drops the transaction.
    step();
    dm_req_valid = 1'b1;
    dm_addr      = 32'h90;
    #1;
    chk("r_dm_ready", 64'(dm_req_ready), 64'd1);
    step();
    dm_req_valid = 1'b0;
    reset        = 1'b1;
    #1;
    chk("r_mem_en", 64'(mem_en), 64'd0);
    chk("r_dm_data", 64'(dm_rsp_data), 64'd0);
    chk("r_if_data", 64'(if_rsp_data), 64'd0);
    expect_none("r_now");
    step();
    reset      = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h9999_9999;
    step();
    mem_rvalid = 1'b0;
    #1;
    expect_none("r_after");
    step();
    #1;
    expect_none("r_after2");
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
